// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator-side controller for a 64x8 single-port synchronous RAM.
// Host requests (read / write / fill) arrive over a valid/ready handshake. The
// controller drives the RAM pins and returns read data over a valid/ready
// response channel. The RAM's registered output is captured one cycle after
// its address is presented.
module ram_access_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              fill_done,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RESP,
        FILL
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fill_cnt;
    logic              accept;
    logic              fill_last;

    // mem_addr and mem_din double as the latched request address and data,
    // so they naturally hold their last values whenever the RAM is idle.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign fill_last = (fill_cnt == ADDR_W'(DEPTH - 1));
    assign busy      = (state != IDLE);
    assign mem_we    = !rst && ((state == WR) || (state == FILL));

    // State register; reset aborts whatever operation is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: reserved op 11 is accepted but leaves the FSM in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_READ:  state_nxt = RD;
                        OP_WRITE: state_nxt = WR;
                        OP_FILL:  state_nxt = FILL;
                        default:  state_nxt = IDLE;
                    endcase
                end
            end
            WR:      state_nxt = IDLE;
            RD:      state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            FILL: begin
                if (fill_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request, walk the fill counter, capture read data and
    // hold the response until the host takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            fill_done <= 1'b0;
            fill_cnt  <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_READ: begin
                                mem_addr <= req_addr;
                            end
                            OP_WRITE: begin
                                mem_addr <= req_addr;
                                mem_din  <= req_wdata;
                            end
                            OP_FILL: begin
                                mem_addr <= '0;
                                mem_din  <= req_wdata;
                                fill_cnt <= '0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    rsp_data  <= mem_dout;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        fill_cnt  <= '0;
                        fill_done <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + ADDR_W'(1);
                        mem_addr <= fill_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Initiator-side controller for the 64x8 single-port synchronous RAM. Accepts read, write and fill requests from a host over a valid/ready handshake and drives the RAM's we/addr/din pins. Captures RAM read data at the correct cycle and returns it over a valid/ready response channel. Sits between host logic and the RAM. The RAM's own rst is tied to the same rst at top level.

Parameters:
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W (64)
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_op  in  2  00 read, 01 write, 10 fill, 11 reserved
req_addr  in  ADDR_W  target address (ignored for fill)
req_wdata  in  DATA_W  write data / fill pattern
rsp_valid  out  1  read data valid
rsp_ready  in  1  host accepts response
rsp_data  out  DATA_W  read data
fill_done  out  1  one-cycle pulse when fill completes
busy  out  1  high whenever state != IDLE
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM registered read data (valid the cycle after the addr is sampled with we=0)

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). All state changes occur on the rising edge of clk.
- Reset: state=IDLE, rsp_valid=0, rsp_data=0, fill_done=0, fill counter=0, mem_we=0, mem_addr=0, mem_din=0.
- While rst is high, req_ready=0 and mem_we=0 regardless of state.
- Reset mid-operation: any in-flight write/read/fill is aborted and any pending response is dropped. No further RAM writes occur after the edge at which rst is sampled.
- Handshake: a request is accepted on an edge where req_valid && req_ready. req_ready=1 only in IDLE with rst=0. Op, addr and wdata are latched at acceptance.
- States:
  - IDLE: mem_we=0.
    - read -> RD
    - write -> WR
    - fill -> FILL with counter=0
    - op 11: accepted, no RAM access, no response, stays IDLE
  - WR: one cycle. mem_we=1, mem_addr=latched addr, mem_din=latched data. Then -> IDLE. No response is generated.
  - RD: one cycle. mem_we=0, mem_addr=latched addr; the RAM samples the address at the end of this cycle. -> RD_WAIT.
  - RD_WAIT: one cycle. mem_dout is now valid. rsp_data<=mem_dout at the exiting edge. -> RESP.
  - RESP: rsp_valid=1, rsp_data held stable. When rsp_ready=1: rsp_valid clears at that edge, -> IDLE.
  - FILL: mem_we=1, mem_addr=counter, mem_din=latched pattern; counter increments each cycle. On the cycle counter==DEPTH-1, fill_done pulses high at the following edge for exactly one cycle, counter wraps to 0, -> IDLE. A fill takes exactly DEPTH cycles.
- Read latency: with the accept edge at T0, rsp_valid is first high in the cycle after edge T0+2, i.e. 2 cycles after acceptance. Minimum read-to-next-accept spacing is 4 cycles (RD, RD_WAIT, RESP with immediate rsp_ready, IDLE).
- Write-after-write spacing is 2 cycles (WR, IDLE). Read-after-write to the same address returns the new data.
- Outside WR and FILL, mem_we=0. mem_addr/mem_din hold their last values when unused.
- Backpressure: while rsp_ready=0, the controller stays in RESP indefinitely with rsp_valid and rsp_data constant, and no new request is accepted.
- busy is combinational from state.

Test Plan:
- Reset, write 0x3C to addr 5, read addr 5 -> mem_we high exactly 1 cycle with addr 5/din 0x3C; rsp_valid rises 2 cycles after read accept with rsp_data=0x3C.
- Read addr 63 after writing 0xFF there, with rsp_ready held 0 for 5 cycles -> rsp_valid stays 1 and rsp_data stays 0xFF for all 5 cycles; req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
- Fill with pattern 0xA5 -> mem_we high 64 consecutive cycles with addr 0..63, fill_done single pulse after addr 63; reads of addr 0, 31, 63 return 0xA5.
- Write 0x11 to addr 30, start fill 0x77, assert rst when counter=20 -> mem_we low from the next cycle, state IDLE, busy=0, fill_done never pulses; read addr 30 after the RAM is reset returns 0x00 (RAM cleared by shared rst).
- Issue op 11 with addr 7 -> accepted in one cycle, mem_we stays 0, no rsp_valid, no fill_done; a following read of addr 7 proceeds normally.
- Back-to-back write 0x01 to addr 0, read addr 0 with req_valid held high -> second request accepted 2 cycles after the first, rsp_data=0x01.
